// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
//   Multi-cycle unsigned multiplier controller. Sequences an external,
//   purely combinational ALU through REG_BITS shift-add iterations to produce
//   the low REG_BITS bits of op_a*op_b, plus an exact unsigned overflow flag.
//   The ALU is only ever asked to add (alu_ctrl = 4'b0000); shifting of the
//   multiplicand and multiplier happens locally.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   operation request, sampled only in IDLE
//   op_a      in   multiplicand, latched on the accepted start
//   op_b      in   multiplier, latched on the accepted start
//   busy      out  high while iterating (RUN)
//   done      out  one-cycle pulse, result/overflow valid from then on
//   result    out  low REG_BITS bits of the product
//   overflow  out  full product >= 2^REG_BITS
//   alu_a     out  ALU operand A (accumulator), 0 outside RUN
//   alu_b     out  ALU operand B (shifted multiplicand), 0 outside RUN
//   alu_ctrl  out  ALU opcode, constant add
//   alu_c     in   ALU sum
//   alu_onzc  in   ALU flags {O,N,Z,C}; only C (bit 0) is used
// -----------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [REG_BITS-1:0] op_a,
    input  logic [REG_BITS-1:0] op_b,
    output logic                busy,
    output logic                done,
    output logic [REG_BITS-1:0] result,
    output logic                overflow,
    output logic [REG_BITS-1:0] alu_a,
    output logic [REG_BITS-1:0] alu_b,
    output logic [3:0]          alu_ctrl,
    input  logic [REG_BITS-1:0] alu_c,
    input  logic [3:0]          alu_onzc
);

    localparam int                CNT_W    = $clog2(REG_BITS) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(REG_BITS - 1);
    localparam logic [3:0]        ALU_ADD  = 4'b0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [REG_BITS-1:0] r_acc;
    logic [REG_BITS-1:0] r_mcand;
    logic [REG_BITS-1:0] r_mplier;
    logic [CNT_W-1:0]    r_count;
    logic                r_sticky_ovf;
    logic                r_lost;        // a 1 has been shifted out of mcand
    logic [REG_BITS-1:0] r_result;
    logic                r_overflow;

    logic                w_add_en;
    logic [REG_BITS-1:0] w_acc_nxt;
    logic                w_ovf_nxt;
    logic                w_last;
    logic                w_unused_flags;

    // Only the carry flag matters for an unsigned add.
    assign w_unused_flags = ^alu_onzc[3:1];

    assign w_add_en  = r_mplier[0];
    assign w_last    = (r_count == LAST_CNT);
    assign w_acc_nxt = w_add_en ? alu_c : r_acc;
    // Any add that carries out, or that uses a multiplicand already truncated
    // by earlier shifts, means the true product does not fit.
    assign w_ovf_nxt = r_sticky_ovf | (w_add_en & (alu_onzc[0] | r_lost));

    // NOTE: sequential state is written only with non-blocking (<=) assignments
    // so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        alu_a        = '0;
        alu_b        = '0;
        alu_ctrl     = ALU_ADD;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                alu_a = r_acc;
                alu_b = r_mcand;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_count      <= '0;
            r_sticky_ovf <= 1'b0;
            r_lost       <= 1'b0;
            r_result     <= '0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand      <= op_a;
                        r_mplier     <= op_b;
                        r_acc        <= '0;
                        r_count      <= '0;
                        r_sticky_ovf <= 1'b0;
                        r_lost       <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_acc        <= w_acc_nxt;
                    r_sticky_ovf <= w_ovf_nxt;
                    r_lost       <= r_lost | r_mcand[REG_BITS-1];
                    r_mcand      <= {r_mcand[REG_BITS-2:0], 1'b0};
                    r_mplier     <= {1'b0, r_mplier[REG_BITS-1:1]};
                    r_count      <= r_count + CNT_W'(1);
                    // Capture the final iteration's values directly so the
                    // outputs are already valid during the DONE cycle.
                    if (w_last) begin
                        r_result   <= w_acc_nxt;
                        r_overflow <= w_ovf_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result   = r_result;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_seq
//   Bench for alu_mul_seq with REG_BITS=5 and a combinational ALU model.
//   Expected {result, overflow} pairs are hand-computed and pushed into a
//   scoreboard when an operation is issued; a monitor pops and compares on
//   every done pulse. Cycle-level checks cover busy/done timing and the
//   ALU-facing outputs.
// -----------------------------------------------------------------------------
module tb_alu_mul_seq;

    localparam int W = 5;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         overflow;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_c;
    logic [3:0]   alu_onzc;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;

    alu_mul_seq #(.REG_BITS(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_ctrl (alu_ctrl),
        .alu_c    (alu_c),
        .alu_onzc (alu_onzc)
    );

    // Combinational ALU: only add (ctrl 0) is modelled, other opcodes give 0.
    always_comb begin
        logic [W:0] sum;
        sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c    = '0;
        alu_onzc = 4'b0000;
        if (alu_ctrl == 4'b0000) begin
            alu_c    = sum[W-1:0];
            alu_onzc = {(alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]),
                        sum[W-1], (sum[W-1:0] == '0), sum[W]};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, expected no pulse (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_result", int'(result), int'(e.res));
                check("sb_overflow", int'(overflow), int'(e.ovf));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_alu_a"}, int'(alu_a), 0);
        check({tag, "_alu_b"}, int'(alu_b), 0);
        check({tag, "_alu_ctrl"}, int'(alu_ctrl), 0);
    endtask

    // One full operation from an IDLE cycle; ends in the IDLE cycle after DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic eo);
        exp_t e;
        e.res = er;
        e.ovf = eo;
        sb.push_back(e);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        tick(1);                       // E0 accepted
        start = 1'b0;
        op_a  = ~a;                    // operands may change freely after E0
        op_b  = ~b;
        for (int i = 0; i < W; i++) begin
            check("run_busy", int'(busy), 1);
            check("run_done", int'(done), 0);
            check("run_alu_ctrl", int'(alu_ctrl), 0);
            tick(1);
        end
        check("done_pulse", int'(done), 1);
        check_quiet("done");
        tick(1);
        check("idle_done", int'(done), 0);
        check_quiet("idle");
        check("idle_result_hold", int'(result), int'(er));
        check("idle_overflow_hold", int'(overflow), int'(eo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_snap;
        exp_t e;
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        tick(2);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_overflow", int'(overflow), 0);
        check_quiet("rst");
        rst_n = 1'b1;
        tick(1);

        run_op(5'd5,  5'd5,  5'd25, 1'b0);
        run_op(5'd6,  5'd6,  5'd4,  1'b1);   // carry-out path
        run_op(5'd16, 5'd2,  5'd0,  1'b1);   // shifted-out path
        run_op(5'd31, 5'd1,  5'd31, 1'b0);
        run_op(5'd0,  5'd31, 5'd0,  1'b0);
        run_op(5'd31, 5'd0,  5'd0,  1'b0);

        // start held high; operands changed mid-RUN. The second op is taken
        // on the first IDLE cycle after DONE with the then-current operands.
        e.res = 5'd21; e.ovf = 1'b0; sb.push_back(e);
        e.res = 5'd18; e.ovf = 1'b0; sb.push_back(e);
        start = 1'b1;
        op_a  = 5'd3;
        op_b  = 5'd7;
        tick(1);                              // E0
        tick(2);
        op_a  = 5'd2;
        op_b  = 5'd9;
        tick(3);                              // E5 -> DONE
        check("held_done1", int'(done), 1);
        check("held_result1", int'(result), 21);
        tick(1);                              // IDLE
        check("held_idle_busy", int'(busy), 0);
        check("held_idle_done", int'(done), 0);
        tick(1);                              // second op accepted
        check("held_restart_busy", int'(busy), 1);
        start = 1'b0;
        tick(W);
        check("held_done2", int'(done), 1);
        tick(1);
        check("held_idle2_done", int'(done), 0);

        // Asynchronous reset on the 3rd RUN cycle of 6*6: no done pulse.
        done_snap = n_done;
        start = 1'b1;
        op_a  = 5'd6;
        op_b  = 5'd6;
        tick(1);                              // E0
        start = 1'b0;
        tick(2);                              // inside RUN cycle 3
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_result", int'(result), 0);
        check("abort_overflow", int'(overflow), 0);
        check_quiet("abort");
        tick(2);
        rst_n = 1'b1;
        tick(W + 2);
        check("abort_no_done", n_done, done_snap);

        run_op(5'd2, 5'd3, 5'd6, 1'b0);

        // Back-to-back; result holds 28 until the next start is accepted.
        run_op(5'd7, 5'd4, 5'd28, 1'b0);
        tick(1);
        check("b2b_hold_result", int'(result), 28);
        run_op(5'd3, 5'd3, 5'd9, 1'b0);

        tick(3);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned multiplier controller that sequences the shared ALU through shift-add iterations.
- Computes the low REG_BITS bits of op_a*op_b and flags unsigned overflow.
- Sits beside the ALU in the execute stage. Drives the ALU's A/B/ctrl inputs and consumes its C and ONZC outputs; shifting is done internally.
- The ALU itself is instantiated outside this block.

Parameters:
- REG_BITS, 5, operand/result width; must match the ALU's REG_BITS.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op_a  input  REG_BITS  multiplicand; latched on the accepted start.
- op_b  input  REG_BITS  multiplier; latched on the accepted start.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse; result and overflow valid from this cycle onward.
- result  output  REG_BITS  low REG_BITS bits of op_a*op_b.
- overflow  output  1  high if the full unsigned product >= 2^REG_BITS.
- alu_a  output  REG_BITS  ALU operand A (accumulator).
- alu_b  output  REG_BITS  ALU operand B (shifted multiplicand).
- alu_ctrl  output  4  ALU opcode; constant 4'b0000 (add).
- alu_c  input  REG_BITS  ALU result.
- alu_onzc  input  4  ALU flags {O,N,Z,C}; bit 0 is the unsigned carry-out.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; acc, mcand, mplier, count, sticky_ovf cleared.
  - busy=0, done=0, result=0, overflow=0, alu_a=0, alu_b=0, alu_ctrl=4'b0000.
  - Reset mid-RUN aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: mcand<=op_a, mplier<=op_b, acc<=0, count<=0, sticky_ovf<=0, lost<=0; go to RUN.
  - start=0: stay in IDLE.
- RUN (exactly REG_BITS cycles, no early exit):
  - Combinational outputs: alu_a=acc, alu_b=mcand, alu_ctrl=4'b0000.
  - Each edge:
    - If mplier[0]=1: acc<=alu_c; sticky_ovf<=sticky_ovf | alu_onzc[0] | lost.
    - lost<=lost | mcand[REG_BITS-1]; mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
  - After the edge where count reaches REG_BITS-1 (the REG_BITS-th RUN edge), go to DONE.
  - busy=1 throughout RUN.
- DONE (one cycle):
  - done=1, busy=0.
  - result=acc and overflow=sticky_ovf are registered on entry and held until the next accepted start.
  - Next edge returns to IDLE.
- Latency: start edge E0 -> done high during the cycle after edge E0+REG_BITS, i.e. REG_BITS+1 cycles. Throughput is one operation per REG_BITS+2 cycles.
- start while in RUN or DONE is ignored: no queuing, latched operands are unaffected.
- op_a/op_b may change freely after E0.
- Outside RUN: alu_a=0, alu_b=0, alu_ctrl=4'b0000.
- Width rules: all arithmetic is modulo 2^REG_BITS. The count register is clog2(REG_BITS)+1 bits.
- Overflow is exact: set iff an add with a carry-out occurs, or an add occurs after a 1 has been shifted out of mcand.
- The block relies on the ALU being purely combinational with add at ctrl 4'b0000 (same-cycle alu_c).

Test Plan (REG_BITS=5, ALU instantiated in the bench):
- 5*5: start with op_a=5, op_b=5 -> busy high for 5 cycles, done pulse on the 6th cycle after start, result=25 (5'b11001), overflow=0.
- 6*6: -> result=4, overflow=1 (carry path). 16*2: -> result=0, overflow=1 (shifted-out path). 31*1: -> result=31, overflow=0.
- 0*31 and 31*0: -> result=0, overflow=0. Check that alu_ctrl stays 4'b0000 and that alu_a/alu_b are 0 in IDLE/DONE.
- start held high continuously with op_a=3, op_b=7, and op_a/op_b changed mid-RUN:
  - Changes are ignored; result=21.
  - Exactly one done pulse per operation; the next operation begins on the first IDLE cycle after DONE.
- Reset mid-RUN: assert rst_n=0 asynchronously on the 3rd RUN cycle of 6*6 -> all outputs are 0 immediately, with no done pulse.
  - After release, 2*3 -> result=6, overflow=0.
- Back-to-back: 7*4 then 3*3 -> result=28 overflow=0, then result=9 overflow=0. result holds 28 until the second start is accepted.
